// File: rtl/usb_serial_pkg.sv
// usb_serial_pkg: shared USB-serial constants and tx arbiter state encoding
package usb_serial_pkg;
    localparam int USB_MAX_PACKET_SIZE = 32;
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;
endpackage

// File: rtl/usb_serial_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin encoder, first mask bit strictly after ptr wins
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] winner_idx,
    output logic          found
);
    logic [PW-1:0] j;
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        j          = '0;
        for (int k = 1; k <= N; k++) begin
            j = PW'((int'(ptr) + k) % N);
            if (!found && mask[j]) begin
                winner[j]  = 1'b1;
                winner_idx = j;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/usb_serial_tx_arbiter.sv
// usb_serial_tx_arbiter: packet-atomic round-robin sharing of the usb_serial_core tx byte pipe
module usb_serial_tx_arbiter
    import usb_serial_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int BURST_MAX = USB_MAX_PACKET_SIZE,
    parameter int IDLE_TMO  = 64
) (
    input  logic              wb_clk_i,
    input  logic              wb_reset_i,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_enable,
    output logic [7:0]        uart_in_data,
    output logic              uart_in_valid,
    input  logic              uart_in_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy
);
    localparam int PW = $clog2(NREQ);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int IW = $clog2(IDLE_TMO + 1);
    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d, pick;
    logic [PW-1:0]   rr_q, rr_d, pick_idx;
    logic [BW-1:0]   burst_q, burst_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic [7:0]      data_q, data_d, sel_data;
    logic            valid_q, valid_d, sel_valid, sel_last, pick_found, can_load, xfer;
    rr_pick #(.N(NREQ), .PW(PW)) u_rr_pick (
        .mask       (req_valid & req_enable),
        .ptr        (rr_q),
        .winner     (pick),
        .winner_idx (pick_idx),
        .found      (pick_found)
    );
    always_comb begin
        sel_data  = '0;
        sel_valid = |(grant_q & req_valid);
        sel_last  = |(grant_q & req_last);
        for (int i = 0; i < NREQ; i++)
            sel_data = sel_data | (grant_q[i] ? req_data[8*i +: 8] : 8'h00);
    end
    assign can_load  = !valid_q || uart_in_ready;
    assign req_ready = (state_q == ARB_GRANT && can_load) ? (grant_q & req_valid) : '0;
    assign xfer      = |req_ready;
    // the output register drains on its own; release never touches a pending byte
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        idle_d  = idle_q;
        data_d  = xfer ? sel_data : data_q;
        valid_d = xfer || (valid_q && !uart_in_ready);
        if (state_q == ARB_IDLE) begin
            if (pick_found) begin
                state_d = ARB_GRANT;
                grant_d = pick;
                rr_d    = pick_idx;
                burst_d = '0;
                idle_d  = '0;
            end
        end else begin
            if (xfer) begin
                burst_d = burst_q + 1'b1;
                idle_d  = '0;
            end else if (!sel_valid && idle_q != IW'(IDLE_TMO)) begin
                idle_d = idle_q + 1'b1;
            end
            if ((xfer && (sel_last || burst_d == BW'(BURST_MAX))) || idle_d == IW'(IDLE_TMO)) begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        end
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            rr_q    <= PW'(NREQ - 1);
            burst_q <= '0;
            idle_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
    assign uart_in_data  = data_q;
    assign uart_in_valid = valid_q;
    assign grant         = grant_q;
    assign busy          = (state_q == ARB_GRANT);
endmodule

// File: tb/tb_usb_serial_tx_arbiter.sv
// tb_usb_serial_tx_arbiter: directed and randomized checks against a packet-level arbitration model
module tb_usb_serial_tx_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic           rst;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_valid, req_last, req_ready, req_enable, grant;
    logic [7:0]     uart_in_data;
    logic           uart_in_valid, uart_in_ready, busy;
    usb_serial_tx_arbiter dut (
        .wb_clk_i      (clk),
        .wb_reset_i    (rst),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .req_enable    (req_enable),
        .uart_in_data  (uart_in_data),
        .uart_in_valid (uart_in_valid),
        .uart_in_ready (uart_in_ready),
        .grant         (grant),
        .busy          (busy)
    );
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [8:0] src [N][$];
    int dn_q[$];
    int up_cyc[$];
    int up_own[$];
    int gl_cyc[$];
    logic [N-1:0] gl_val[$];
    logic [N-1:0] prev_g = '0;
    logic [N-1:0] rdy_seen = '0;
    int exp_own[$];
    int exp_bytes[$];
    int d0, u0, g0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        rdy_seen = rst ? '0 : req_ready;
        if (!rst) begin
            if (uart_in_valid && uart_in_ready) dn_q.push_back(int'(uart_in_data));
            for (int i = 0; i < N; i++)
                if (req_ready[i]) begin
                    up_cyc.push_back(cyc);
                    up_own.push_back(i);
                end
        end
        if (grant !== prev_g) begin
            gl_cyc.push_back(cyc);
            gl_val.push_back(grant);
            prev_g = grant;
        end
    end
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = src[i].size() > 0;
            req_last[i]         = req_valid[i] ? src[i][0][8] : 1'b0;
            req_data[8*i +: 8]  = req_valid[i] ? src[i][0][7:0] : 8'h00;
        end
    endtask
    task automatic step(input bit rnd);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (rdy_seen[i] && src[i].size() > 0) void'(src[i].pop_front());
        if (rnd) uart_in_ready = ($urandom_range(0, 1) == 1);
        drive();
    endtask
    task automatic set_marks();
        d0 = dn_q.size();
        u0 = up_cyc.size();
        g0 = gl_cyc.size();
    endtask
    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) src[i].delete();
        req_enable    = '1;
        uart_in_ready = 1'b1;
        drive();
        repeat (2) step(0);
        rst = 1'b0;
        set_marks();
    endtask
    task automatic push_pkt(input int r, input int len, input int base, input bit with_last);
        for (int k = 0; k < len; k++)
            src[r].push_back({with_last && (k == len - 1), 8'(base + k)});
    endtask
    // reference: grants go to the next non-empty enabled requester after the previous owner;
    // a grant carries bytes until a last byte, BURST_MAX bytes, or the requester runs dry
    task automatic model_run(input logic [N-1:0] en);
        logic [8:0] m [N][$];
        int ptr, w, n;
        logic [8:0] b;
        for (int i = 0; i < N; i++) m[i] = src[i];
        exp_own.delete();
        exp_bytes.delete();
        ptr = N - 1;
        forever begin
            w = -1;
            for (int k = 1; k <= N && w < 0; k++)
                if (en[(ptr + k) % N] && m[(ptr + k) % N].size() > 0) w = (ptr + k) % N;
            if (w < 0) break;
            exp_own.push_back(w);
            ptr = w;
            n = 0;
            do begin
                b = m[w].pop_front();
                exp_bytes.push_back(int'(b[7:0]));
                n++;
            end while (!b[8] && n < 32 && m[w].size() > 0);
        end
    endtask
    function automatic int stream_diff();
        int n = dn_q.size() - d0;
        if (n != exp_bytes.size()) return 1000 + n;
        for (int k = 0; k < n; k++) if (dn_q[d0 + k] != exp_bytes[k]) return k;
        return -1;
    endfunction
    function automatic int owner_diff();
        int got[$];
        for (int k = g0; k < gl_val.size(); k++) begin
            if (!$onehot0(gl_val[k])) return 2000;
            for (int i = 0; i < N; i++) if (gl_val[k][i]) got.push_back(i);
        end
        if (got.size() != exp_own.size()) return 1000 + got.size();
        foreach (got[k]) if (got[k] != exp_own[k]) return k;
        return -1;
    endfunction
    function automatic int gap_bad();
        int c = 0;
        for (int k = g0 + 1; k < gl_val.size(); k++)
            if (gl_val[k] != '0 && gl_val[k-1] == '0 && gl_cyc[k] - gl_cyc[k-1] != 1) c++;
        return c;
    endfunction
    task automatic run_until_idle(input int max_cyc, input bit rnd, input string name);
        bit done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            step(rnd);
            done = !busy && grant == '0 && !uart_in_valid;
            for (int i = 0; i < N; i++) if (src[i].size() > 0) done = 1'b0;
        end
        uart_in_ready = 1'b1;
        repeat (2) step(0);
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_timeout: traffic still pending after %0d cycles, required drained", name, max_cyc);
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        req_enable = '1;
        uart_in_ready = 1'b1;
        drive();
        repeat (2) step(0);
        @(negedge clk);
        total++;
        if (grant !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_fsm: grant=%b busy=%b, required 0000/0", grant, busy);
        end
        total++;
        if (uart_in_valid !== 1'b0 || uart_in_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_out: valid=%b data=%h, required 0/00", uart_in_valid, uart_in_data);
        end
        total++;
        if (req_ready !== '0) begin
            bad++;
            $display("FAIL reset_ready: req_ready=%b, required 0000", req_ready);
        end
    endtask
    task automatic test_single();
        do_reset();
        push_pkt(0, 3, 'h41, 1'b1);
        drive();
        model_run('1);
        @(negedge clk);
        total++;
        if (grant !== 4'b0000 || req_valid[0] !== 1'b1) begin
            bad++;
            $display("FAIL single_pregrant: grant=%b, required 0000 in the valid cycle", grant);
        end
        step(0);
        @(negedge clk);
        total++;
        if (grant !== 4'b0001 || req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL single_grant: grant=%b req_ready=%b, required 0001/0001", grant, req_ready);
        end
        run_until_idle(50, 0, "single");
        total++;
        if (stream_diff() != -1) begin
            bad++;
            $display("FAIL single_stream: diff code %0d, got %0d bytes, required 41,42,43", stream_diff(), dn_q.size() - d0);
        end
        total++;
        if (gl_val.size() == 0 || gl_val[gl_val.size()-1] != '0 || up_cyc.size() == 0 ||
            gl_cyc[gl_cyc.size()-1] != up_cyc[up_cyc.size()-1] + 1) begin
            bad++;
            $display("FAIL single_release: release not one cycle after last accept (cyc %0d vs %0d)",
                     gl_cyc.size() ? gl_cyc[gl_cyc.size()-1] : -1, up_cyc.size() ? up_cyc[up_cyc.size()-1] : -1);
        end
    endtask
    task automatic test_round_robin();
        do_reset();
        push_pkt(0, 2, 'h00, 1'b1);
        push_pkt(0, 2, 'h08, 1'b1);
        for (int r = 1; r < N; r++) push_pkt(r, 2, 16 * r, 1'b1);
        drive();
        model_run('1);
        run_until_idle(200, 0, "rr");
        total++;
        if (owner_diff() != -1) begin
            bad++;
            $display("FAIL rr_order: diff code %0d, required %0d grants in order 0,1,2,3,0", owner_diff(), exp_own.size());
        end
        total++;
        if (stream_diff() != -1) begin
            bad++;
            $display("FAIL rr_stream: diff code %0d, required %0d unbroken packet bytes", stream_diff(), exp_bytes.size());
        end
        total++;
        if (gap_bad() != 0) begin
            bad++;
            $display("FAIL rr_gap: %0d grant gaps not exactly one idle cycle, required 0", gap_bad());
        end
    endtask
    task automatic test_burst_split();
        do_reset();
        push_pkt(1, 40, 'h01, 1'b0);
        push_pkt(2, 3, 'hC0, 1'b1);
        drive();
        model_run('1);
        run_until_idle(400, 0, "burst");
        total++;
        if (owner_diff() != -1) begin
            bad++;
            $display("FAIL burst_order: diff code %0d, required grants 1,2,1", owner_diff());
        end
        total++;
        if (stream_diff() != -1) begin
            bad++;
            $display("FAIL burst_stream: diff code %0d, required 32 bytes of req1, req2 packet, bytes 33..40", stream_diff());
        end
        total++;
        if (gl_cyc.size() < g0 + 2 || up_cyc.size() < u0 + 32 || gl_val[g0+1] != '0 ||
            gl_cyc[g0+1] != up_cyc[u0+31] + 1) begin
            bad++;
            $display("FAIL burst_release: release not on the cycle after byte 32");
        end
    endtask
    task automatic test_backpressure();
        bit seen = 1'b0;
        do_reset();
        uart_in_ready = 1'b0;
        push_pkt(0, 3, 'h5A, 1'b1);
        drive();
        model_run('1);
        for (int k = 0; k < 10 && !seen; k++) begin
            step(0);
            seen = uart_in_valid;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL bp_load: uart_in_valid=0 after 10 cycles, required 1");
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if (uart_in_valid !== 1'b1 || uart_in_data !== 8'h5A || req_ready !== '0) begin
                bad++;
                $display("FAIL bp_hold: valid=%b data=%h req_ready=%b, required 1/5a/0000", uart_in_valid, uart_in_data, req_ready);
            end
            step(0);
        end
        uart_in_ready = 1'b1;
        run_until_idle(50, 0, "bp");
        total++;
        if (stream_diff() != -1) begin
            bad++;
            $display("FAIL bp_stream: diff code %0d, required exactly 5a,5b,5c", stream_diff());
        end
    endtask
    task automatic test_idle_timeout();
        do_reset();
        push_pkt(0, 2, 'h11, 1'b0);
        push_pkt(3, 1, 'h33, 1'b1);
        drive();
        model_run('1);
        run_until_idle(300, 0, "idle");
        total++;
        if (owner_diff() != -1) begin
            bad++;
            $display("FAIL idle_order: diff code %0d, required grants 0,3", owner_diff());
        end
        total++;
        if (gl_cyc.size() < g0 + 3 || up_cyc.size() < u0 + 2 || gl_val[g0+1] != '0 ||
            gl_cyc[g0+1] != up_cyc[u0+1] + 65) begin
            bad++;
            $display("FAIL idle_release: release %0d cycles after last byte, required 65",
                     (gl_cyc.size() > g0 + 1 && up_cyc.size() > u0 + 1) ? gl_cyc[g0+1] - up_cyc[u0+1] : -1);
        end
        total++;
        if (stream_diff() != -1 || gap_bad() != 0) begin
            bad++;
            $display("FAIL idle_next: stream code %0d gaps %0d, required -1/0", stream_diff(), gap_bad());
        end
    endtask
    task automatic test_reset_mid();
        bit seen = 1'b0;
        do_reset();
        uart_in_ready = 1'b0;
        push_pkt(1, 5, 'h70, 1'b1);
        drive();
        for (int k = 0; k < 10 && !seen; k++) begin
            step(0);
            seen = uart_in_valid && busy;
        end
        rst = 1'b1;
        step(0);
        @(negedge clk);
        total++;
        if (!seen || grant !== '0 || busy !== 1'b0 || req_ready !== '0) begin
            bad++;
            $display("FAIL rstmid_fsm: seen=%b grant=%b busy=%b req_ready=%b, required 1/0000/0/0000", seen, grant, busy, req_ready);
        end
        total++;
        if (uart_in_valid !== 1'b0 || uart_in_data !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_out: valid=%b data=%h, required 0/00", uart_in_valid, uart_in_data);
        end
        rst = 1'b0;
        src[1].delete();
        req_enable = 4'b1110;
        uart_in_ready = 1'b1;
        drive();
        step(0);
        set_marks();
        push_pkt(0, 3, 'hA0, 1'b1);
        push_pkt(2, 2, 'hB0, 1'b1);
        drive();
        model_run(req_enable);
        repeat (40) step(0);
        total++;
        if (owner_diff() != -1 || src[0].size() != 3) begin
            bad++;
            $display("FAIL rstmid_disabled: owner code %0d req0 left %0d, required -1/3", owner_diff(), src[0].size());
        end
        total++;
        if (stream_diff() != -1) begin
            bad++;
            $display("FAIL rstmid_stream: diff code %0d, required only req2 bytes", stream_diff());
        end
    endtask
    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int r = 0; r < N; r++)
                if ($urandom_range(0, 3) != 0)
                    for (int p = int'($urandom_range(1, 3)); p > 0; p--)
                        push_pkt(r, ($urandom_range(0, 4) == 0) ? int'($urandom_range(30, 45)) : int'($urandom_range(1, 8)),
                                 int'($urandom_range(0, 255)), 1'b1);
            drive();
            model_run('1);
            run_until_idle(5000, 1, "rand");
            total++;
            if (owner_diff() != -1) begin
                bad++;
                $display("FAIL rand_order[%0d]: diff code %0d, required %0d grants", it, owner_diff(), exp_own.size());
            end
            total++;
            if (stream_diff() != -1) begin
                bad++;
                $display("FAIL rand_stream[%0d]: diff code %0d, required %0d bytes", it, stream_diff(), exp_bytes.size());
            end
            total++;
            if (gap_bad() != 0) begin
                bad++;
                $display("FAIL rand_gap[%0d]: %0d bad gaps, required 0", it, gap_bad());
            end
        end
    endtask
    initial begin
        rst = 1'b1;
        req_enable = '1;
        uart_in_ready = 1'b1;
        drive();
        test_reset();
        test_single();
        test_round_robin();
        test_burst_split();
        test_backpressure();
        test_idle_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
